// File: rtl/icache_axi_refill_engine.sv
// ============================================================================
// Module  : icache_axi_refill_engine
// Brief   : Multi-outstanding L1I$ refill engine onto an AXI4 read channel,
//           with ID-tagged slots, per-slot line reassembly, error and flush.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module icache_axi_refill_engine #(
    parameter int unsigned LineWidth      = 128,
    parameter int unsigned AxiDataWidth   = 64,
    parameter int unsigned AxiAddrWidth   = 64,
    parameter int unsigned AxiIdWidth     = 4,
    parameter int unsigned NumOutstanding = 2,
    parameter int unsigned TidWidth       = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    flush_i,
    output logic                    busy_o,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic [AxiAddrWidth-1:0] req_paddr_i,
    input  logic                    req_nc_i,
    input  logic [TidWidth-1:0]     req_tid_i,
    output logic                    rtrn_valid_o,
    output logic [LineWidth-1:0]    rtrn_data_o,
    output logic [TidWidth-1:0]     rtrn_tid_o,
    output logic                    rtrn_err_o,
    output logic                    ar_valid_o,
    input  logic                    ar_ready_i,
    output logic [AxiAddrWidth-1:0] ar_addr_o,
    output logic [7:0]              ar_len_o,
    output logic [2:0]              ar_size_o,
    output logic [AxiIdWidth-1:0]   ar_id_o,
    input  logic                    r_valid_i,
    output logic                    r_ready_o,
    input  logic [AxiDataWidth-1:0] r_data_i,
    input  logic [AxiIdWidth-1:0]   r_id_i,
    input  logic                    r_last_i,
    input  logic [1:0]              r_resp_i
);

    localparam int unsigned WORDS_PER_LINE = LineWidth / AxiDataWidth;
    localparam int unsigned CNT_W          = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;
    localparam int unsigned SLOT_W         = (NumOutstanding > 1) ? $clog2(NumOutstanding) : 1;
    localparam int unsigned WORD_OFF       = $clog2(AxiDataWidth / 8);
    localparam int unsigned LINE_OFF       = $clog2(LineWidth / 8);

    localparam logic [AxiAddrWidth-1:0] LINE_MASK = ~(AxiAddrWidth'(LineWidth / 8 - 1));
    localparam logic [AxiAddrWidth-1:0] WORD_MASK = ~(AxiAddrWidth'(AxiDataWidth / 8 - 1));

    localparam logic [1:0] S_FREE   = 2'd0;
    localparam logic [1:0] S_BUSY   = 2'd1;
    localparam logic [1:0] S_KILLED = 2'd2;

    logic [1:0]              slot_state_q [NumOutstanding];
    logic [1:0]              slot_state_d [NumOutstanding];
    logic [NumOutstanding-1:0] slot_occ;
    logic [NumOutstanding-1:0] slot_live;
    logic [NumOutstanding-1:0] beat_hit;

    logic [TidWidth-1:0]     tid_q   [NumOutstanding];
    logic                    nc_q    [NumOutstanding];
    logic [CNT_W-1:0]        woff_q  [NumOutstanding];
    logic [CNT_W-1:0]        cnt_q   [NumOutstanding];
    logic                    err_q   [NumOutstanding];
    logic [LineWidth-1:0]    data_q  [NumOutstanding];
    logic [CNT_W-1:0]        word_idx[NumOutstanding];

    logic                    ar_valid_q;
    logic [AxiAddrWidth-1:0] ar_addr_q;
    logic [7:0]              ar_len_q;
    logic [2:0]              ar_size_q;
    logic [AxiIdWidth-1:0]   ar_id_q;

    logic                    rtrn_valid_q;
    logic [LineWidth-1:0]    rtrn_data_q;
    logic [TidWidth-1:0]     rtrn_tid_q;
    logic                    rtrn_err_q;

    logic                    any_free;
    logic [SLOT_W-1:0]       alloc_idx;
    logic                    accept;
    logic [CNT_W-1:0]        req_woff;
    logic [LineWidth-1:0]    cpl_line;
    logic [TidWidth-1:0]     cpl_tid;
    logic                    cpl_err;
    logic                    cpl_live;
    logic                    cpl_fire;
    logic                    unused_resp0;

    assign unused_resp0 = r_resp_i[0];

    generate
        if (WORDS_PER_LINE > 1) begin : g_woff
            assign req_woff = req_paddr_i[LINE_OFF-1:WORD_OFF];
        end else begin : g_woff_single
            assign req_woff = '0;
        end
    endgenerate

    // Lowest-index free slot wins allocation.
    always_comb begin
        any_free  = 1'b0;
        alloc_idx = '0;
        for (int s = NumOutstanding - 1; s >= 0; s--) begin
            if (!slot_occ[s]) begin
                any_free  = 1'b1;
                alloc_idx = SLOT_W'(s);
            end
        end
    end

    assign req_ready_o = any_free && (!ar_valid_q || ar_ready_i) && !flush_i;
    assign accept      = req_valid_i && req_ready_o;

    // Route the R beat and build the completed line including the current beat.
    always_comb begin
        beat_hit = '0;
        cpl_line = '0;
        cpl_tid  = '0;
        cpl_err  = 1'b0;
        cpl_live = 1'b0;
        for (int s = 0; s < NumOutstanding; s++) begin
            word_idx[s] = nc_q[s] ? woff_q[s] : cnt_q[s];
            beat_hit[s] = r_valid_i && slot_occ[s] && (r_id_i == AxiIdWidth'(s));
            if (beat_hit[s]) begin
                cpl_line = data_q[s];
                cpl_line[word_idx[s]*AxiDataWidth +: AxiDataWidth] = r_data_i;
                cpl_tid  = tid_q[s];
                cpl_err  = err_q[s] | r_resp_i[1];
                cpl_live = slot_live[s];
            end
        end
    end

    assign cpl_fire = r_last_i && cpl_live && !flush_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int s = 0; s < NumOutstanding; s++) begin
                slot_state_q[s] <= S_FREE;
            end
        end else begin
            for (int s = 0; s < NumOutstanding; s++) begin
                slot_state_q[s] <= slot_state_d[s];
            end
        end
    end

    // A last beat frees the slot even when a flush arrives in the same cycle.
    always_comb begin
        for (int s = 0; s < NumOutstanding; s++) begin
            slot_state_d[s] = slot_state_q[s];
            case (slot_state_q[s])
                S_FREE: begin
                    if (accept && (alloc_idx == SLOT_W'(s))) begin
                        slot_state_d[s] = S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (beat_hit[s] && r_last_i) begin
                        slot_state_d[s] = S_FREE;
                    end else if (flush_i) begin
                        slot_state_d[s] = S_KILLED;
                    end
                end
                S_KILLED: begin
                    if (beat_hit[s] && r_last_i) begin
                        slot_state_d[s] = S_FREE;
                    end
                end
                default: slot_state_d[s] = S_FREE;
            endcase
        end
    end

    always_comb begin
        for (int s = 0; s < NumOutstanding; s++) begin
            slot_occ[s]  = (slot_state_q[s] != S_FREE);
            slot_live[s] = (slot_state_q[s] == S_BUSY);
        end
        busy_o = |slot_occ;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int s = 0; s < NumOutstanding; s++) begin
                tid_q[s]  <= '0;
                nc_q[s]   <= 1'b0;
                woff_q[s] <= '0;
                cnt_q[s]  <= '0;
                err_q[s]  <= 1'b0;
                data_q[s] <= '0;
            end
        end else begin
            for (int s = 0; s < NumOutstanding; s++) begin
                if (accept && (alloc_idx == SLOT_W'(s))) begin
                    tid_q[s]  <= req_tid_i;
                    nc_q[s]   <= req_nc_i;
                    woff_q[s] <= req_woff;
                    cnt_q[s]  <= '0;
                    err_q[s]  <= 1'b0;
                    data_q[s] <= '0;
                end else if (beat_hit[s]) begin
                    data_q[s][word_idx[s]*AxiDataWidth +: AxiDataWidth] <= r_data_i;
                    err_q[s] <= err_q[s] | r_resp_i[1];
                    cnt_q[s] <= r_last_i ? '0 : cnt_q[s] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ar_valid_q <= 1'b0;
            ar_addr_q  <= '0;
            ar_len_q   <= '0;
            ar_size_q  <= '0;
            ar_id_q    <= '0;
        end else if (accept) begin
            ar_valid_q <= 1'b1;
            ar_addr_q  <= req_nc_i ? (req_paddr_i & WORD_MASK) : (req_paddr_i & LINE_MASK);
            ar_len_q   <= req_nc_i ? 8'd0 : 8'(WORDS_PER_LINE - 1);
            ar_size_q  <= 3'(WORD_OFF);
            ar_id_q    <= AxiIdWidth'(alloc_idx);
        end else if (ar_ready_i) begin
            ar_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rtrn_valid_q <= 1'b0;
            rtrn_data_q  <= '0;
            rtrn_tid_q   <= '0;
            rtrn_err_q   <= 1'b0;
        end else begin
            rtrn_valid_q <= cpl_fire;
            if (cpl_fire) begin
                rtrn_data_q <= cpl_line;
                rtrn_tid_q  <= cpl_tid;
                rtrn_err_q  <= cpl_err;
            end
        end
    end

    // R beats for an unoccupied slot are dropped; flag them in simulation.
    always @(posedge clk_i) begin
        if (rst_ni && r_valid_i) begin
            assert (|beat_hit);
        end
    end

    assign ar_valid_o   = ar_valid_q;
    assign ar_addr_o    = ar_addr_q;
    assign ar_len_o     = ar_len_q;
    assign ar_size_o    = ar_size_q;
    assign ar_id_o      = ar_id_q;
    assign r_ready_o    = 1'b1;
    assign rtrn_valid_o = rtrn_valid_q;
    assign rtrn_data_o  = rtrn_data_q;
    assign rtrn_tid_o   = rtrn_tid_q;
    assign rtrn_err_o   = rtrn_err_q;

endmodule

`default_nettype wire

// File: tb/tb_icache_axi_refill_engine.sv
// ============================================================================
// Module  : tb_icache_axi_refill_engine
// Brief   : Directed and randomized bench for icache_axi_refill_engine,
//           acting as AXI slave and comparing against a transaction model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_icache_axi_refill_engine;

    localparam int LW = 128;
    localparam int DW = 64;
    localparam int AW = 64;
    localparam int IW = 4;
    localparam int N  = 2;
    localparam int TW = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          flush = 1'b0, req_valid = 1'b0, req_nc = 1'b0, ar_ready = 1'b0;
    logic [AW-1:0] req_paddr = '0;
    logic [TW-1:0] req_tid = '0;
    logic          r_valid = 1'b0, r_last = 1'b0;
    logic [DW-1:0] r_data = '0;
    logic [IW-1:0] r_id = '0;
    logic [1:0]    r_resp = '0;
    logic          busy, req_ready, rtrn_valid, rtrn_err, ar_valid, r_ready;
    logic [LW-1:0] rtrn_data;
    logic [TW-1:0] rtrn_tid;
    logic [AW-1:0] ar_addr;
    logic [7:0]    ar_len;
    logic [2:0]    ar_size;
    logic [IW-1:0] ar_id;

    icache_axi_refill_engine #(
        .LineWidth(LW), .AxiDataWidth(DW), .AxiAddrWidth(AW),
        .AxiIdWidth(IW), .NumOutstanding(N), .TidWidth(TW)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .busy_o(busy),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_paddr_i(req_paddr),
        .req_nc_i(req_nc), .req_tid_i(req_tid),
        .rtrn_valid_o(rtrn_valid), .rtrn_data_o(rtrn_data), .rtrn_tid_o(rtrn_tid),
        .rtrn_err_o(rtrn_err),
        .ar_valid_o(ar_valid), .ar_ready_i(ar_ready), .ar_addr_o(ar_addr),
        .ar_len_o(ar_len), .ar_size_o(ar_size), .ar_id_o(ar_id),
        .r_valid_i(r_valid), .r_ready_o(r_ready), .r_data_i(r_data), .r_id_i(r_id),
        .r_last_i(r_last), .r_resp_i(r_resp)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 0;

    // Transaction-level model: slot table, pending AR, expected return.
    bit            m_occ [N], m_kill [N], m_nc [N], m_err [N], m_iss [N];
    logic [TW-1:0] m_tid [N];
    int            m_woff [N], m_left [N], m_cnt [N];
    logic [LW-1:0] m_line [N];
    bit            m_arv;
    logic [AW-1:0] m_araddr;
    int            m_arlen, m_arid;
    bit            m_rv, m_rerr;
    logic [LW-1:0] m_rdata;
    logic [TW-1:0] m_rtid;

    task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit any_occ();
        bit f = 0;
        for (int s = 0; s < N; s++) f |= m_occ[s];
        return f;
    endfunction

    function automatic bit model_ready();
        bit f = 0;
        for (int s = 0; s < N; s++) if (!m_occ[s]) f = 1;
        return f && (!m_arv || ar_ready) && !flush;
    endfunction

    task automatic model_reset();
        for (int s = 0; s < N; s++) begin
            m_occ[s] = 0; m_kill[s] = 0; m_iss[s] = 0; m_left[s] = 0; m_cnt[s] = 0;
        end
        m_arv = 0;
        m_rv  = 0;
    endtask

    // Apply the driven inputs to the model for the coming clock edge.
    task automatic model_update();
        int fs = -1;
        bit acc = req_valid && model_ready();
        for (int s = N - 1; s >= 0; s--) if (!m_occ[s]) fs = s;
        m_rv = 0;
        if (flush) for (int s = 0; s < N; s++) if (m_occ[s]) m_kill[s] = 1;
        if (r_valid && m_occ[int'(r_id)]) begin
            int id = int'(r_id);
            int w  = m_nc[id] ? m_woff[id] : m_cnt[id];
            m_line[id][w*DW +: DW] = r_data;
            m_err[id] |= r_resp[1];
            m_cnt[id]++;
            m_left[id]--;
            if (r_last) begin
                if (!m_kill[id]) begin
                    m_rv = 1; m_rdata = m_line[id]; m_rtid = m_tid[id]; m_rerr = m_err[id];
                end
                m_occ[id] = 0; m_kill[id] = 0; m_iss[id] = 0; m_cnt[id] = 0;
            end
        end
        if (m_arv && ar_ready) begin
            m_iss[m_arid]  = 1;
            m_left[m_arid] = m_arlen + 1;
            m_arv = 0;
        end
        if (acc) begin
            m_occ[fs] = 1; m_kill[fs] = 0; m_tid[fs] = req_tid; m_nc[fs] = req_nc;
            m_woff[fs] = int'((req_paddr / (DW / 8)) % (LW / DW));
            m_line[fs] = '0; m_err[fs] = 0; m_cnt[fs] = 0; m_iss[fs] = 0;
            m_arv    = 1;
            m_araddr = req_nc ? req_paddr - req_paddr % (DW / 8) : req_paddr - req_paddr % (LW / 8);
            m_arlen  = req_nc ? 0 : LW / DW - 1;
            m_arid   = fs;
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", LW'(busy), LW'(any_occ()));
            chk("req_ready", LW'(req_ready), LW'(model_ready()));
            chk("r_ready", LW'(r_ready), LW'(1'b1));
            chk("ar_valid", LW'(ar_valid), LW'(m_arv));
            if (m_arv) begin
                chk("ar_addr", LW'(ar_addr), LW'(m_araddr));
                chk("ar_len", LW'(ar_len), LW'(m_arlen));
                chk("ar_size", LW'(ar_size), LW'($clog2(DW / 8)));
                chk("ar_id", LW'(ar_id), LW'(m_arid));
            end
            chk("rtrn_valid", LW'(rtrn_valid), LW'(m_rv));
            if (m_rv) begin
                chk("rtrn_data", rtrn_data, m_rdata);
                chk("rtrn_tid", LW'(rtrn_tid), LW'(m_rtid));
                chk("rtrn_err", LW'(rtrn_err), LW'(m_rerr));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic request(input logic [AW-1:0] pa, input logic nc, input logic [TW-1:0] tid);
        req_valid = 1; req_paddr = pa; req_nc = nc; req_tid = tid;
        tick();
        req_valid = 0;
    endtask

    task automatic beat(input int id, input logic [DW-1:0] d, input logic [1:0] resp);
        r_valid = 1; r_id = IW'(id); r_data = d; r_resp = resp;
        r_last = (m_left[id] == 1);
        tick();
        r_valid = 0; r_last = 0;
    endtask

    task automatic pick_beat(input bit en);
        int q[$];
        for (int s = 0; s < N; s++) if (m_iss[s] && m_left[s] > 0) q.push_back(s);
        if (en && q.size() > 0) begin
            int id = q[$urandom % q.size()];
            int v  = $urandom % 8;
            r_valid = 1; r_id = IW'(id); r_data = {$urandom, $urandom};
            r_resp  = (v == 0) ? 2'b10 : (v == 1) ? 2'b11 : (v == 2) ? 2'b01 : 2'b00;
            r_last  = (m_left[id] == 1);
        end else begin
            r_valid = 0; r_last = 0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1);
    end

    initial begin
        model_reset();
        #2;
        chk("rst_busy", LW'(busy), '0);
        chk("rst_rtrn_valid", LW'(rtrn_valid), '0);
        chk("rst_rtrn_err", LW'(rtrn_err), '0);
        chk("rst_rtrn_data", rtrn_data, '0);
        chk("rst_ar_valid", LW'(ar_valid), '0);
        chk("rst_ar_addr", LW'(ar_addr), '0);
        repeat (2) @(posedge clk);
        #1;
        rst_n  = 1;
        chk_en = 1;

        // Cacheable line, two beats.
        request(64'h8000_0014, 1'b0, 2'd1);
        chk("t1_ar_valid", LW'(ar_valid), LW'(1'b1));
        chk("t1_ar_addr", LW'(ar_addr), LW'(64'h8000_0010));
        chk("t1_ar_len", LW'(ar_len), LW'(8'd1));
        chk("t1_ar_size", LW'(ar_size), LW'(3'd3));
        chk("t1_ar_id", LW'(ar_id), '0);
        ar_ready = 1;
        tick();
        beat(0, 64'hAAAA_0001_AAAA_0001, 2'b00);
        beat(0, 64'hBBBB_0002_BBBB_0002, 2'b00);
        chk("t1_rtrn_valid", LW'(rtrn_valid), LW'(1'b1));
        chk("t1_rtrn_data", rtrn_data, 128'hBBBB_0002_BBBB_0002_AAAA_0001_AAAA_0001);
        chk("t1_rtrn_tid", LW'(rtrn_tid), LW'(2'd1));
        chk("t1_rtrn_err", LW'(rtrn_err), '0);
        tick();
        chk("t1_idle_busy", LW'(busy), '0);

        // Non-cacheable single word into the upper half.
        request(64'h1008, 1'b1, 2'd2);
        chk("t2_ar_addr", LW'(ar_addr), LW'(64'h1008));
        chk("t2_ar_len", LW'(ar_len), '0);
        tick();
        beat(0, 64'hDDDD_DDDD_1234_5678, 2'b00);
        chk("t2_rtrn_data", rtrn_data, 128'hDDDD_DDDD_1234_5678_0000_0000_0000_0000);
        chk("t2_rtrn_tid", LW'(rtrn_tid), LW'(2'd2));

        // Two outstanding, ID1 completes first, third request stalls.
        request(64'h2000, 1'b0, 2'd0);
        request(64'h3000, 1'b0, 2'd1);
        req_valid = 1; req_paddr = 64'h4000; req_nc = 0; req_tid = 2'd2;
        #1;
        chk("t3_stall", LW'(req_ready), '0);
        tick();
        beat(1, 64'hE0, 2'b00);
        beat(1, 64'hE1, 2'b00);
        chk("t3_first_tid", LW'(rtrn_tid), LW'(2'd1));
        chk("t3_first_data", rtrn_data, {64'hE1, 64'hE0});
        tick();
        req_valid = 0;
        chk("t3_reuse_id", LW'(ar_id), LW'(4'd1));
        beat(0, 64'hF0, 2'b00);
        beat(0, 64'hF1, 2'b00);
        chk("t3_second_tid", LW'(rtrn_tid), LW'(2'd0));
        chk("t3_second_data", rtrn_data, {64'hF1, 64'hF0});
        beat(1, 64'h60, 2'b00);
        beat(1, 64'h61, 2'b00);
        chk("t3_third_tid", LW'(rtrn_tid), LW'(2'd2));
        tick();

        // AR backpressure, then error response.
        ar_ready = 0;
        request(64'h5000, 1'b0, 2'd3);
        req_valid = 1; req_paddr = 64'h6000; req_nc = 0; req_tid = 2'd0;
        for (int i = 0; i < 5; i++) begin
            chk("t4_ready_low", LW'(req_ready), '0);
            chk("t4_ar_stable", LW'(ar_addr), LW'(64'h5000));
            tick();
        end
        ar_ready = 1;
        #1;
        chk("t4_ready_resume", LW'(req_ready), LW'(1'b1));
        tick();
        req_valid = 0;
        tick();
        beat(0, 64'h70, 2'b00);
        beat(0, 64'h71, 2'b00);
        beat(1, 64'h80, 2'b00);
        beat(1, 64'h81, 2'b10);
        chk("t5_err", LW'(rtrn_err), LW'(1'b1));
        chk("t5_err_tid", LW'(rtrn_tid), LW'(2'd0));

        // Flush mid-burst.
        request(64'h7000, 1'b0, 2'd1);
        tick();
        beat(0, 64'h90, 2'b00);
        flush = 1;
        tick();
        flush = 0;
        chk("t6_busy_killed", LW'(busy), LW'(1'b1));
        beat(0, 64'h91, 2'b00);
        chk("t6_no_rtrn", LW'(rtrn_valid), '0);
        chk("t6_busy_fall", LW'(busy), '0);

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            req_valid = 1'($urandom % 2);
            req_paddr = {$urandom, $urandom};
            req_nc    = ($urandom % 4 == 0);
            req_tid   = TW'($urandom);
            ar_ready  = ($urandom % 4 != 0);
            flush     = ($urandom % 50 == 0);
            pick_beat(($urandom % 3) != 0);
            tick();
        end
        req_valid = 0; flush = 0; ar_ready = 1;
        for (int c = 0; c < 100; c++) begin
            if (!any_occ()) break;
            pick_beat(1);
            tick();
        end
        r_valid = 0; r_last = 0;
        tick();
        chk("drain_busy", LW'(busy), '0);

        // Reset in the middle of a burst.
        request(64'h9000, 1'b0, 2'd0);
        tick();
        beat(0, 64'hA0, 2'b00);
        chk_en = 0;
        rst_n  = 0;
        #1;
        chk("midrst_busy", LW'(busy), '0);
        chk("midrst_ar_valid", LW'(ar_valid), '0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n  = 1;
        chk_en = 1;
        request(64'hA000, 1'b0, 2'd2);
        chk("post_rst_id", LW'(ar_id), '0);
        tick();
        beat(0, 64'hB0, 2'b00);
        beat(0, 64'hB1, 2'b00);
        chk("post_rst_data", rtrn_data, {64'hB1, 64'hB0});
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
